// File: rtl/alu_sweep_checker.sv
// Exhaustive self-test sequencer for a 3-bit signed ALU: sweeps all op/operand
// combinations (operand -4 excluded), compares result and flags, and records errors.
module alu_sweep_checker (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic [1:0] S,
  input  logic [4:0] R,
  input  logic       SF,
  input  logic       ZF,
  input  logic       DZF,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic       fail_valid,
  output logic [1:0] fail_S,
  output logic [2:0] fail_A,
  output logic [2:0] fail_B,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_MIN = 3'b101;  // -3
  localparam logic [2:0] OP_MAX = 3'b011;  // +3

  state_t state;

  logic signed [4:0] a_ext;
  logic signed [4:0] b_ext;
  logic signed [4:0] exp_r;
  logic              exp_dzf;
  logic              exp_sf;
  logic              exp_zf;
  logic              mismatch;
  logic              last_vec;

  assign dbg_state = state;
  assign a_ext     = {{2{A[2]}}, A};
  assign b_ext     = {{2{B[2]}}, B};

  // Reference ALU; all results fit in 5 bits so no overflow handling is needed.
  always_comb begin
    exp_r   = '0;
    exp_dzf = 1'b0;
    case (S)
      2'b00: exp_r = a_ext + b_ext;
      2'b01: exp_r = a_ext - b_ext;
      2'b10: exp_r = a_ext * b_ext;
      default: begin
        if (b_ext == 5'sd0) exp_dzf = 1'b1;
        else                exp_r   = a_ext % b_ext;
      end
    endcase
  end

  assign exp_sf   = exp_r[4];
  assign exp_zf   = (exp_r == 5'sd0);
  assign mismatch = (R != exp_r) || (SF != exp_sf) || (ZF != exp_zf) || (DZF != exp_dzf);
  assign last_vec = (S == 2'b11) && (A == OP_MAX) && (B == OP_MAX);

  // start is a level request sampled only in IDLE/DONE; there is no ready/ack,
  // busy rising on the following edge is the acceptance indication.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      A          <= '0;
      B          <= '0;
      S          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_S     <= '0;
      fail_A     <= '0;
      fail_B     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= DRIVE;
            A          <= OP_MIN;
            B          <= OP_MIN;
            S          <= 2'b00;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_S     <= '0;
            fail_A     <= '0;
            fail_B     <= '0;
          end
        end
        DRIVE: state <= CHECK;
        CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 8'd1;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_S     <= S;
              fail_A     <= A;
              fail_B     <= B;
            end
          end
          if (last_vec) begin
            // Final vector stays on A/B/S so it remains visible in DONE.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 8'd0) && !mismatch;
          end else begin
            state <= DRIVE;
            if (B == OP_MAX) begin
              B <= OP_MIN;
              if (A == OP_MAX) begin
                A <= OP_MIN;
                S <= S + 2'd1;
              end else begin
                A <= A + 3'd1;
              end
            end else begin
              B <= B + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_sweep_checker.md
ALU_SWEEP_CHECKER -- requirements
Module: alu_sweep_checker

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request a full sweep; sampled on clk.
REQ-004 SHALL have port A, output, 3 bits: operand A driven to the ALU, two's complement.
REQ-005 SHALL have port B, output, 3 bits: operand B driven to the ALU, two's complement.
REQ-006 SHALL have port S, output, 2 bits: ALU op select; 00 add, 01 sub, 10 mul, 11 remainder.
REQ-007 SHALL have port R, input, 5 bits: ALU result, two's complement.
REQ-008 SHALL have ports SF, ZF, DZF, inputs, 1 bit each: ALU sign, zero and divide-by-zero flags.
REQ-009 SHALL have port busy, output, 1 bit: sweep in progress.
REQ-010 SHALL have port done, output, 1 bit: sweep complete; held until restart or reset.
REQ-011 SHALL have port pass, output, 1 bit: valid when done=1; 1 iff err_count=0.
REQ-012 SHALL have port err_count, output, 8 bits: number of mismatching vectors.
REQ-013 SHALL have ports fail_valid (1 bit), fail_S (2), fail_A (3), fail_B (3), outputs: first mismatching vector.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, CHECK, DONE.
REQ-015 IDLE/DONE with start=1: SHALL clear err_count, fail_valid and fail_* fields, load S=00, A=-3 (101), B=-3 (101), and go to DRIVE.
REQ-016 start SHALL be ignored in DRIVE and CHECK.
REQ-017 DRIVE: SHALL hold A/B/S stable for one cycle for ALU settling, then go to CHECK.
REQ-018 CHECK: SHALL compare R, SF, ZF and DZF against the expected values in one cycle; any difference counts as one error for that vector.
REQ-019 On error: err_count SHALL increment by 1; if fail_valid=0, SHALL capture S/A/B into fail_S/fail_A/fail_B and set fail_valid=1.
REQ-020 Sweep order SHALL be B innermost (-3..3), then A (-3..3), then S outermost (00..11): 196 vectors; operand value 100 (-4) is never driven.
REQ-021 After CHECK: at B=3, B SHALL wrap to -3 and A SHALL advance; at A=3, A SHALL wrap to -3 and S SHALL advance; after the CHECK of S=11, A=3, B=3 the FSM SHALL go to DONE, otherwise to DRIVE.
REQ-022 Expected R SHALL be computed on 5-bit sign-extended operands: 00 A+B, 01 A-B, 10 A*B (ranges -9..9; no overflow).
REQ-023 For S=11 with B!=0, expected R SHALL equal the truncated remainder of A/B, with sign following A (e.g. -3 rem 2 = -1), and expected DZF SHALL be 0.
REQ-024 For S=11 with B=0, expected R SHALL be 0 and expected DZF SHALL be 1; for all other ops expected DZF SHALL be 0.
REQ-025 Expected SF SHALL equal expected R[4]; expected ZF SHALL be 1 iff expected R=0, including the DZF case.
REQ-026 busy SHALL be 1 in DRIVE and CHECK only; done SHALL be 1 in DONE only; pass SHALL be 0 outside DONE.
REQ-027 A, B and S SHALL be 000/000/00 in IDLE and SHALL hold the last vector in DONE.
REQ-028 Latency: counting the edge that samples start as edge 1, done SHALL rise after edge 393.

Reset
REQ-029 rst=1 SHALL force on the next edge: state IDLE; A=000, B=000, S=00; busy, done, pass and fail_valid 0; err_count 0; fail_* 0.
REQ-030 rst SHALL take priority over start and over any in-progress sweep.

Verification
REQ-031 Golden ALU connected, start pulsed -> done=1 after edge 393, err_count=0, pass=1, fail_valid=0.
REQ-032 ALU R forced to 0 while S=00, flags golden -> err_count=42, pass=0, fail_S=00, fail_A=101, fail_B=101.
REQ-033 ALU DZF tied 0 -> err_count=7, fail_S=11, fail_A=101, fail_B=000.
REQ-034 rst pulsed at edge 100 of a sweep -> next edge all outputs at reset values; a following start runs a full 196-vector sweep, done after edge 393.
REQ-035 start held high continuously -> no restart while busy; in DONE the sweep restarts on the next edge (done drops, counters cleared).
